// File: rtl/r200_pkg.sv
// Shared r200 core types: data/register widths, func3 and wbsel encodings,
// and the packed EX/MEM beat carried through the pipeline register.
package r200_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   // func3 access-size field (bits [1:0]); bit 2 marks the unsigned load variants
   localparam logic [2:0] F3_BYTE  = 3'b000;
   localparam logic [2:0] F3_HALF  = 3'b001;
   localparam logic [2:0] F3_WORD  = 3'b010;
   localparam logic [2:0] F3_BYTEU = 3'b100;
   localparam logic [2:0] F3_HALFU = 3'b101;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   typedef struct packed {
      logic            regwr;
      logic            memwr;
      logic            memrd;
      logic [1:0]      wbsel;
      logic [RAW-1:0]  rdaddr;
      logic [2:0]      func3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [3:0]      strb;
      logic            misalign;
   } beat_t;

   function automatic logic [1:0] f3_size(input logic [2:0] f3);
      return f3[1:0];
   endfunction

endpackage

// File: rtl/ex_mem_reg_store_align.sv
// store_align: places store data on its byte lanes, builds the byte strobes and
// flags an address that is not naturally aligned for the access size.
module store_align
   import r200_pkg::*;
(
   input  logic [1:0]      size,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rs2o,
   output logic [XLEN-1:0] wdata,
   output logic [3:0]      wstrb,
   output logic            misalign
);

   logic [3:0] strb_raw;

   always_comb begin
      wdata    = rs2o;
      strb_raw = 4'b1111;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata    = {4{rs2o[7:0]}};
            strb_raw = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            wdata    = {2{rs2o[15:0]}};
            strb_raw = 4'b0011 << addr_lo;
            misalign = addr_lo[0];
         end
         default: begin
            misalign = (addr_lo != 2'b00);
         end
      endcase
      wstrb = misalign ? 4'b0000 : strb_raw;
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer so ex_ready is a flop.
// Optional EX forwarding port enabled by defining EX_MEM_FWD_EN.
module ex_mem_reg
   import r200_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_regwr,
   input  logic        ex_memwr,
   input  logic        ex_memrd,
   input  logic [1:0]  ex_wbsel,
   input  logic [4:0]  ex_rdaddr,
   input  logic [2:0]  ex_func3,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_rs2o,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_regwr,
   output logic        mem_memwr,
   output logic        mem_memrd,
   output logic [1:0]  mem_wbsel,
   output logic [4:0]  mem_rdaddr,
   output logic [2:0]  mem_func3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_misalign,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rdaddr,
   output logic [31:0] fwd_data
);

   beat_t main_q, main_d, skid_q, skid_d, in_beat;
   logic  main_valid_q, main_valid_d;
   logic  skid_valid_q, skid_valid_d;
   logic  ex_ready_q, ex_ready_d;

   logic [XLEN-1:0] al_wdata;
   logic [3:0]      al_wstrb;
   logic            al_misalign;

   store_align u_align (
      .size     (f3_size(ex_func3)),
      .addr_lo  (ex_alu_out[1:0]),
      .rs2o     (ex_rs2o),
      .wdata    (al_wdata),
      .wstrb    (al_wstrb),
      .misalign (al_misalign)
   );

   // Strobes only belong to stores; misalignment matters for any memory access.
   always_comb begin
      in_beat          = '0;
      in_beat.regwr    = ex_regwr && (ex_rdaddr != 5'd0);
      in_beat.memwr    = ex_memwr;
      in_beat.memrd    = ex_memrd;
      in_beat.wbsel    = ex_wbsel;
      in_beat.rdaddr   = ex_rdaddr;
      in_beat.func3    = ex_func3;
      in_beat.addr     = ex_alu_out;
      in_beat.data     = al_wdata;
      in_beat.strb     = ex_memwr ? al_wstrb : 4'b0000;
      in_beat.misalign = (ex_memwr || ex_memrd) && al_misalign;
   end

   logic accept, xfer, main_load;
   assign accept    = ex_valid && ex_ready_q && !flush;
   assign xfer      = main_valid_q && mem_ready;
   assign main_load = !main_valid_q || xfer;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_load) begin
         // A skid beat only exists while ex_ready is low, so accept is 0 here.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            if (accept) begin
               main_d = in_beat;
            end
            main_valid_d = accept;
         end
      end else if (accept) begin
         skid_d       = in_beat;
         skid_valid_d = 1'b1;
      end
      ex_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ex_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ex_ready_q   <= ex_ready_d;
      end
   end

   assign ex_ready     = ex_ready_q;
   assign mem_valid    = main_valid_q;
   assign mem_regwr    = main_q.regwr;
   assign mem_memwr    = main_q.memwr;
   assign mem_memrd    = main_q.memrd;
   assign mem_wbsel    = main_q.wbsel;
   assign mem_rdaddr   = main_q.rdaddr;
   assign mem_func3    = main_q.func3;
   assign mem_addr     = main_q.addr;
   assign mem_wdata    = main_q.data;
   assign mem_wstrb    = main_valid_q ? main_q.strb : 4'b0000;
   assign mem_misalign = main_valid_q && main_q.misalign;

`ifdef EX_MEM_FWD_EN
   assign fwd_valid  = main_valid_q && main_q.regwr && !main_q.memrd;
   assign fwd_rdaddr = main_q.rdaddr;
   assign fwd_data   = main_q.addr;
`else
   assign fwd_valid  = 1'b0;
   assign fwd_rdaddr = 5'd0;
   assign fwd_data   = 32'd0;
`endif

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline boundary of the r200 core. It captures the EX-stage result beat (ALU result, store data, writeback controls) and presents it to the data-memory stage through a valid/ready handshake. A two-entry skid buffer keeps the upstream stall (`ex_ready`) fully registered when data memory back-pressures. It also generates the aligned store byte-strobes and data, and flags misaligned accesses.

## Interface
- No parameters; widths are fixed by the shared package (XLEN = 32, register address = 5).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: trap/kill; drops every beat held or arriving this cycle.
- `ex_valid` in 1: the EX beat is valid.
- `ex_ready` out 1: the block can accept a beat. Driven from a flop.
- `ex_regwr`, `ex_memwr`, `ex_memrd` in 1 each: writeback and memory controls.
- `ex_wbsel` in 2: writeback source select.
- `ex_rdaddr` in 5: destination register.
- `ex_func3` in 3: access size and sign.
- `ex_alu_out` in 32: ALU result, also the memory address.
- `ex_rs2o` in 32: raw store data.
- `mem_valid` out 1: the output beat is valid.
- `mem_ready` in 1: data memory accepts the output beat.
- `mem_regwr`, `mem_memwr`, `mem_memrd` out 1 each.
- `mem_wbsel` out 2.
- `mem_rdaddr` out 5.
- `mem_func3` out 3.
- `mem_addr` out 32: registered ALU result.
- `mem_wdata` out 32: store data shifted to its byte lane.
- `mem_wstrb` out 4: byte strobes. Zero unless the beat is a valid, aligned store.
- `mem_misalign` out 1: the valid output beat is a misaligned load or store.
- `fwd_valid` out 1, `fwd_rdaddr` out 5, `fwd_data` out 32: EX forwarding source (see Configuration).

## Operation
- Storage: a main (output) entry and a skid entry, each with its own valid bit.
- Accept: `ex_valid && ex_ready && !flush`.
- Output transfer: `mem_valid && mem_ready`.
- Main entry loads when it is empty or transferring:
  - from the skid entry if the skid is valid;
  - otherwise from the accepted input.
- Skid entry loads the accepted input when the main entry is full and not transferring.
- A skid beat always drains before any new input beat. Order is preserved.
- `ex_ready` next = !(skid valid next).
- Write-enable suppression: an `ex_regwr` with `ex_rdaddr == 0` is captured as `mem_regwr = 0`.
- Store alignment (derived from `func3[1:0]` and `addr[1:0]`, captured in the same cycle as the beat):
  - Byte: strobe `4'b0001 << addr[1:0]`; data is `rs2o[7:0]` replicated into all lanes.
  - Half: strobe `4'b0011 << addr[1:0]`; data is `rs2o[15:0]` replicated. Misaligned if `addr[0]`.
  - Word: strobe `4'b1111`; data is `rs2o`. Misaligned if `addr[1:0] != 0`.
  - A misaligned store forces the strobe to 0 and sets `mem_misalign`.
- Flush:
  - Both valid bits clear at the next edge and the input that cycle is dropped.
  - `ex_ready` returns to 1 at the next edge.
  - `flush` has priority over accept and transfer.
- Output payload is held stable while `mem_valid && !mem_ready`.

## Timing
- Latency: one cycle from accept to `mem_valid` when the main entry is empty or transferring.
- `ex_ready` falls one cycle after the skid entry fills. No combinational path from `mem_ready` to `ex_ready`.
- Throughput is one beat per cycle while `mem_ready` is held high.
- Back-pressure sequence:
  - `mem_ready` low with both entries full: `ex_ready = 0`.
  - First `mem_ready` high: the skid moves to main and `ex_ready = 1` next cycle.
- Reset values (asynchronous, on `rst_n` low, including mid-transfer):
  - All valid bits 0 and `ex_ready = 1`.
  - All `mem_*` and `fwd_*` outputs 0.
- `mem_wstrb` and `mem_misalign` read 0 whenever `mem_valid = 0`.

## Configuration
- `EX_MEM_FWD_EN` defined:
  - `fwd_valid = mem_valid && mem_regwr && !mem_memrd`.
  - `fwd_rdaddr = mem_rdaddr`; `fwd_data = mem_addr`.
  - All three are combinational from the main entry.
- `EX_MEM_FWD_EN` undefined: the `fwd_*` outputs are tied to 0. The ports remain.

## Structure
- `r200_pkg` holds the XLEN and register-address width constants, `func3` size encodings (byte/half/word, unsigned variants), `wbsel` encodings, and the packed beat struct (controls, `rdaddr`, `func3`, addr, data, strobe, misalign).
- Sub-module `store_align`: combinational; `func3` + addr + `rs2o` -> `wdata` / `wstrb` / misalign. Instantiated once on the input path.

## Test plan
- **Basic pass-through:** reset; one SW beat with addr `0x100`, `rs2o` `0xDEADBEEF`, `mem_ready = 1` -> next cycle `mem_valid = 1`, `mem_wstrb = 4'hF`, `mem_wdata = 0xDEADBEEF`.
- **Byte store:** SB with addr `0x103`, `rs2o` `0x000000AB` -> `mem_wstrb = 4'b1000`, `mem_wdata = 0xABABABAB`, `mem_misalign = 0`.
- **Misaligned store:** SH with addr `0x101` -> `mem_wstrb = 0`, `mem_misalign = 1`. SW with addr `0x102` -> the same response.
- **Back-pressure and ordering:** stream beats A, B, C with `mem_ready = 0` -> A in main, B in skid, `ex_ready = 0` one cycle later, C stalled upstream. Raise `mem_ready` -> output order is A, B, C with no duplication.
- **Flush:** flush with both entries full and `ex_valid = 1` -> next cycle `mem_valid = 0`, `ex_ready = 1`, and no beat emerges.
- **x0 write and async reset:** a `regwr` beat with rd = 0 -> `mem_regwr = 0`. Then pull `rst_n` low mid-stall -> all outputs 0 immediately and `ex_ready = 1`. With `EX_MEM_FWD_EN` defined, check that `fwd_valid` stays 0 for this rd = 0 beat.
